// File: rtl/mips_registers_bank.sv
// MIPS general-purpose register file: two combinational read ports, one synchronous write port.
// Optional write-through bypass enabled by defining REGISTERS_BANK_BYPASS_EN.
module mips_registers_bank #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int BANK_DEPTH = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_reg_write,
    input  logic [NB_ADDR-1:0] i_read_reg_a,
    input  logic [NB_ADDR-1:0] i_read_reg_b,
    input  logic [NB_ADDR-1:0] i_write_reg,
    input  logic [NB_DATA-1:0] i_write_data,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b
);

    logic [NB_DATA-1:0] r_bank [BANK_DEPTH];
    logic               w_wr_en;

    assign w_wr_en = i_reg_write && !i_reset && (i_write_reg != '0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_bank[i_write_reg] <= i_write_data;
        end
    end

`ifdef REGISTERS_BANK_BYPASS_EN
    // Write-through: a read hitting the register being written sees the new data this cycle.
    logic w_byp_a;
    logic w_byp_b;

    assign w_byp_a = w_wr_en && (i_read_reg_a == i_write_reg);
    assign w_byp_b = w_wr_en && (i_read_reg_b == i_write_reg);
`else
    logic w_byp_a;
    logic w_byp_b;

    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    // Address 0 is forced to zero on read so it is valid even before the first reset.
    always_comb begin
        o_data_a = '0;
        if (i_read_reg_a != '0) begin
            o_data_a = w_byp_a ? i_write_data : r_bank[i_read_reg_a];
        end
    end

    always_comb begin
        o_data_b = '0;
        if (i_read_reg_b != '0) begin
            o_data_b = w_byp_b ? i_write_data : r_bank[i_read_reg_b];
        end
    end

endmodule

// File: tb/tb_mips_registers_bank.sv
// Directed bench for mips_registers_bank: vector table plus hand sequences for
// reset, same-cycle read/write and reset-during-write.
module tb_mips_registers_bank;

    logic        i_clock;
    logic        i_reset;
    logic        i_reg_write;
    logic [4:0]  i_read_reg_a;
    logic [4:0]  i_read_reg_b;
    logic [4:0]  i_write_reg;
    logic [31:0] i_write_data;
    logic [31:0] o_data_a;
    logic [31:0] o_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [8];

    mips_registers_bank #(
        .NB_DATA    (32),
        .NB_ADDR    (5),
        .BANK_DEPTH (32)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_reg_write  (i_reg_write),
        .i_read_reg_a (i_read_reg_a),
        .i_read_reg_b (i_read_reg_b),
        .i_write_reg  (i_write_reg),
        .i_write_data (i_write_data),
        .o_data_a     (o_data_a),
        .o_data_b     (o_data_b)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_pre;

        vecs[0] = '{1'b1, 5'd10, 32'd99,         5'd10, 5'd0,  32'd99,         32'd0};
        vecs[1] = '{1'b1, 5'd1,  32'd555,        5'd1,  5'd10, 32'd555,        32'd99};
        vecs[2] = '{1'b1, 5'd0,  32'd111,        5'd1,  5'd0,  32'd555,        32'd0};
        vecs[3] = '{1'b0, 5'd10, 32'hDEADBEEF,   5'd10, 5'd10, 32'd99,         32'd99};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF,   5'd31, 5'd0,  32'hFFFFFFFF,   32'd0};
        vecs[5] = '{1'b1, 5'd31, 32'h80000001,   5'd31, 5'd31, 32'h80000001,   32'h80000001};
        vecs[6] = '{1'b0, 5'd0,  32'h0BADF00D,   5'd0,  5'd31, 32'd0,          32'h80000001};
        vecs[7] = '{1'b1, 5'd2,  32'hA5A5A5A5,   5'd2,  5'd1,  32'hA5A5A5A5,   32'd555};

        i_reset      = 1'b0;
        i_reg_write  = 1'b0;
        i_read_reg_a = 5'd0;
        i_read_reg_b = 5'd0;
        i_write_reg  = 5'd0;
        i_write_data = 32'd0;
        #1;
        check("pre_reset_r0_a", o_data_a, 32'd0);
        check("pre_reset_r0_b", o_data_b, 32'd0);

        // Reset held for two edges
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        @(posedge i_clock);
        #1;
        i_read_reg_a = 5'd10;
        i_read_reg_b = 5'd31;
        #1;
        check("reset_r10_a", o_data_a, 32'd0);
        check("reset_r31_b", o_data_b, 32'd0);
        @(negedge i_clock);
        i_reset      = 1'b0;
        i_read_reg_a = 5'd0;
        i_read_reg_b = 5'd10;
        #1;
        check("reset_r0_a", o_data_a, 32'd0);
        check("reset_r10_b", o_data_b, 32'd0);

        for (int k = 0; k < 8; k++) begin
            @(negedge i_clock);
            i_reg_write  = vecs[k].we;
            i_write_reg  = vecs[k].wa;
            i_write_data = vecs[k].wd;
            i_read_reg_a = vecs[k].ra;
            i_read_reg_b = vecs[k].rb;
            @(posedge i_clock);
            #1;
            check($sformatf("vec%0d_a", k), o_data_a, vecs[k].exp_a);
            check($sformatf("vec%0d_b", k), o_data_b, vecs[k].exp_b);
        end

        // Same-cycle read/write of register 5 (holds 0 since reset)
        @(negedge i_clock);
        i_reg_write  = 1'b1;
        i_write_reg  = 5'd5;
        i_write_data = 32'h1234;
        i_read_reg_a = 5'd5;
        i_read_reg_b = 5'd0;
`ifdef REGISTERS_BANK_BYPASS_EN
        exp_pre = 32'h1234;
`else
        exp_pre = 32'd0;
`endif
        #1;
        check("rw_same_pre_a", o_data_a, exp_pre);
        check("rw_same_pre_b0", o_data_b, 32'd0);
        @(posedge i_clock);
        #1;
        check("rw_same_post_a", o_data_a, 32'h1234);

        // Write to r0 with r0 read: never bypassed
        @(negedge i_clock);
        i_write_reg  = 5'd0;
        i_write_data = 32'd111;
        i_read_reg_a = 5'd0;
        i_read_reg_b = 5'd5;
        #1;
        check("r0_write_pre_a", o_data_a, 32'd0);
        @(posedge i_clock);
        #1;
        check("r0_write_post_a", o_data_a, 32'd0);
        check("r0_write_post_b", o_data_b, 32'h1234);

        // Reset asserted together with a write to r3
        @(negedge i_clock);
        i_reset      = 1'b1;
        i_reg_write  = 1'b1;
        i_write_reg  = 5'd3;
        i_write_data = 32'd7;
        i_read_reg_a = 5'd3;
        i_read_reg_b = 5'd1;
        @(posedge i_clock);
        #1;
        check("midreset_r3_a", o_data_a, 32'd0);
        check("midreset_r1_b", o_data_b, 32'd0);
        i_read_reg_a = 5'd10;
        i_read_reg_b = 5'd5;
        #1;
        check("midreset_r10_a", o_data_a, 32'd0);
        check("midreset_r5_b", o_data_b, 32'd0);
        @(negedge i_clock);
        i_reset      = 1'b0;
        i_reg_write  = 1'b0;
        i_read_reg_a = 5'd3;
        i_read_reg_b = 5'd2;
        @(posedge i_clock);
        #1;
        check("after_reset_r3_a", o_data_a, 32'd0);
        check("after_reset_r2_b", o_data_b, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
